// File: rtl/ov7670_pixel_capture_pkg.sv
// Shared types and constants for the OV7670 RGB565 pixel capture block.
package ov7670_pixel_capture_pkg;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned CH_W       = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LUMA_W     = 7;
    localparam int unsigned LUMA_WR    = 2;
    localparam int unsigned LUMA_WG    = 5;
    localparam int unsigned LUMA_WB    = 1;
    localparam int unsigned LUMA_SHIFT = 3;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb444_t;

endpackage

// File: rtl/ov7670_pixel_capture_rgb565_to_rgb444.sv
// Combinational RGB565 byte pair to RGB444 conversion.
// With CAPTURE_GRAYSCALE_EN defined, all three channels carry the 4-bit luma instead.
module rgb565_to_rgb444
    import ov7670_pixel_capture_pkg::*;
(
    input  logic [7:0]  hi_i,
    input  logic [7:0]  lo_i,
    output logic [11:0] pix_o
);

    rgb444_t rgb_c;
    logic    unused_c;

    // hi = RRRRRGGG, lo = GGGBBBBB; keep the top bits of each field
    always_comb begin
        rgb_c   = '0;
        rgb_c.r = hi_i[7:4];
        rgb_c.g = {hi_i[2:0], lo_i[7]};
        rgb_c.b = lo_i[4:1];
    end

    assign unused_c = ^{hi_i[3], lo_i[6:5], lo_i[0]};

`ifdef CAPTURE_GRAYSCALE_EN
    logic [LUMA_W-1:0] luma_c;
    logic [CH_W-1:0]   y_c;

    always_comb begin
        luma_c = LUMA_W'(LUMA_WR) * {3'b000, rgb_c.r}
               + LUMA_W'(LUMA_WG) * {3'b000, rgb_c.g}
               + LUMA_W'(LUMA_WB) * {3'b000, rgb_c.b};
        y_c    = CH_W'(luma_c >> LUMA_SHIFT);
        pix_o  = {y_c, y_c, y_c};
    end
`else
    assign pix_o = rgb_c;
`endif

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 pixel capture: frame/line FSM, pixel counters and registered RGB444 output.
// Optional macro CAPTURE_GRAYSCALE_EN selects luma output in the converter.
module ov7670_pixel_capture
    import ov7670_pixel_capture_pkg::*;
#(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [BYTE_W-1:0]   cam_data,
    input  logic                byte_en,
    output logic                o_valid,
    output logic [COORD_W-1:0]  x_pixel,
    output logic [COORD_W-1:0]  y_pixel,
    output logic [CH_W-1:0]     o_r,
    output logic [CH_W-1:0]     o_g,
    output logic [CH_W-1:0]     o_b,
    output logic                o_sof,
    output logic                o_frame_done,
    output logic                o_err
);

    localparam logic [COORD_W-1:0] W_LIM = COORD_W'(IMG_W);
    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(IMG_H);

    cap_state_e          state_q;
    logic                phase_q;
    logic                href_q;
    logic [BYTE_W-1:0]   hi_q;
    logic [COORD_W-1:0]  x_q;
    logic [COORD_W-1:0]  y_q;
    logic [11:0]         pix_c;
    rgb444_t             rgb_c;

    rgb565_to_rgb444 u_conv (
        .hi_i  (hi_q),
        .lo_i  (cam_data),
        .pix_o (pix_c)
    );

    assign rgb_c = rgb444_t'(pix_c);

    // Everything advances only on byte_en samples; strobes are single-cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_VS;
            phase_q      <= 1'b0;
            href_q       <= 1'b0;
            hi_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            o_valid      <= 1'b0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            o_r          <= '0;
            o_g          <= '0;
            o_b          <= '0;
            x_pixel      <= '0;
            y_pixel      <= '0;
        end else begin
            o_valid      <= 1'b0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            if (byte_en) begin
                case (state_q)
                    WAIT_VS: begin
                        if (cam_vsync) state_q <= VBLANK;
                    end
                    VBLANK: begin
                        if (!cam_vsync) begin
                            state_q <= ACTIVE;
                            x_q     <= '0;
                            y_q     <= '0;
                            o_err   <= 1'b0;
                            phase_q <= 1'b0;
                            href_q  <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (cam_vsync) begin
                            state_q <= VBLANK;
                            phase_q <= 1'b0;
                            href_q  <= 1'b0;
                            if (x_q != '0 || y_q != '0) o_frame_done <= 1'b1;
                        end else begin
                            href_q <= cam_href;
                            if (href_q && !cam_href) begin
                                // end of line: a pending high byte is an error
                                phase_q <= 1'b0;
                                if (phase_q) o_err <= 1'b1;
                                if (x_q != '0) begin
                                    x_q <= '0;
                                    if (y_q < H_LIM) y_q <= y_q + COORD_W'(1);
                                end
                            end else if (cam_href) begin
                                if (!phase_q) begin
                                    hi_q    <= cam_data;
                                    phase_q <= 1'b1;
                                end else begin
                                    phase_q <= 1'b0;
                                    if (x_q < W_LIM && y_q < H_LIM) begin
                                        o_valid <= 1'b1;
                                        o_sof   <= (x_q == '0) && (y_q == '0);
                                        x_pixel <= x_q;
                                        y_pixel <= y_q;
                                        o_r     <= rgb_c.r;
                                        o_g     <= rgb_c.g;
                                        o_b     <= rgb_c.b;
                                        x_q     <= x_q + COORD_W'(1);
                                    end else begin
                                        o_err <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: state_q <= WAIT_VS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed self-checking bench for ov7670_pixel_capture.
module tb_ov7670_pixel_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic       byte_en = 1'b0;
    logic       o_valid;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic [3:0] o_r;
    logic [3:0] o_g;
    logic [3:0] o_b;
    logic       o_sof;
    logic       o_frame_done;
    logic       o_err;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int fd_cnt = 0;
    logic [9:0] last_x = '0;

    ov7670_pixel_capture #(.IMG_W(320), .IMG_H(240)) dut (
        .clk          (clk),
        .reset        (reset),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .byte_en      (byte_en),
        .o_valid      (o_valid),
        .x_pixel      (x_pixel),
        .y_pixel      (y_pixel),
        .o_r          (o_r),
        .o_g          (o_g),
        .o_b          (o_b),
        .o_sof        (o_sof),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            last_x = x_pixel;
        end
        if (o_frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    // One byte_en cycle; returns on the negedge right after the sampling edge
    task automatic send_byte(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        byte_en   = 1'b1;
        @(negedge clk);
        byte_en   = 1'b0;
    endtask

    task automatic start_frame();
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({o_valid, o_sof, o_frame_done, o_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {o_valid, o_sof, o_frame_done, o_err}); end
        checks++; if ({o_r, o_g, o_b} !== 12'h000) begin
            failures++; $display("FAIL reset_rgb got=%h exp=000", {o_r, o_g, o_b}); end
        checks++; if (x_pixel !== 10'd0 || y_pixel !== 10'd0) begin
            failures++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", x_pixel, y_pixel); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_pixel();
        start_frame();
        send_byte(1'b0, 1'b1, 8'hF8);
        checks++; if (o_valid !== 1'b0) begin
            failures++; $display("FAIL first_hi_novalid got=%b exp=0", o_valid); end
        send_byte(1'b0, 1'b1, 8'h00);
        checks++; if (o_valid !== 1'b1 || o_sof !== 1'b1) begin
            failures++; $display("FAIL first_valid_sof got=%b%b exp=11", o_valid, o_sof); end
        checks++; if ({o_r, o_g, o_b} !== 12'hF00) begin
            failures++; $display("FAIL first_rgb got=%h exp=f00", {o_r, o_g, o_b}); end
        checks++; if (x_pixel !== 10'd0 || y_pixel !== 10'd0) begin
            failures++; $display("FAIL first_xy got=%0d,%0d exp=0,0", x_pixel, y_pixel); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || o_sof !== 1'b0 || {o_r, o_g, o_b} !== 12'hF00) begin
            failures++; $display("FAIL first_hold got=%b%b %h exp=00 f00", o_valid, o_sof, {o_r, o_g, o_b}); end
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_two_pixels();
        send_byte(1'b0, 1'b1, 8'h07);
        send_byte(1'b0, 1'b1, 8'hE0);
        checks++; if (o_valid !== 1'b1 || {o_r, o_g, o_b} !== 12'h0F0 || x_pixel !== 10'd0 || y_pixel !== 10'd1 || o_sof !== 1'b0) begin
            failures++; $display("FAIL green_px got=%b %h x=%0d y=%0d sof=%b exp=1 0f0 x=0 y=1 sof=0",
                                 o_valid, {o_r, o_g, o_b}, x_pixel, y_pixel, o_sof); end
        send_byte(1'b0, 1'b1, 8'h00);
        send_byte(1'b0, 1'b1, 8'h1F);
        checks++; if (o_valid !== 1'b1 || {o_r, o_g, o_b} !== 12'h00F || x_pixel !== 10'd1 || y_pixel !== 10'd1) begin
            failures++; $display("FAIL blue_px got=%b %h x=%0d y=%0d exp=1 00f x=1 y=1",
                                 o_valid, {o_r, o_g, o_b}, x_pixel, y_pixel); end
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_line_overflow();
        start_frame();
        checks++; if (o_err !== 1'b0) begin
            failures++; $display("FAIL ovf_err_start got=%b exp=0", o_err); end
        valid_cnt = 0;
        for (int p = 0; p < 320; p++) begin
            send_byte(1'b0, 1'b1, 8'h12);
            send_byte(1'b0, 1'b1, 8'h34);
        end
        checks++; if (o_err !== 1'b0) begin
            failures++; $display("FAIL ovf_err_at_320 got=%b exp=0", o_err); end
        send_byte(1'b0, 1'b1, 8'h12);
        send_byte(1'b0, 1'b1, 8'h34);
        @(negedge clk);
        checks++; if (valid_cnt != 320) begin
            failures++; $display("FAIL ovf_count got=%0d exp=320", valid_cnt); end
        checks++; if (last_x !== 10'd319) begin
            failures++; $display("FAIL ovf_last_x got=%0d exp=319", last_x); end
        checks++; if (o_err !== 1'b1) begin
            failures++; $display("FAIL ovf_err got=%b exp=1", o_err); end
        send_byte(1'b0, 1'b0, 8'h00);
        start_frame();
        checks++; if (o_err !== 1'b0) begin
            failures++; $display("FAIL ovf_err_clear got=%b exp=0", o_err); end
    endtask

    task automatic test_odd_bytes();
        valid_cnt = 0;
        send_byte(1'b0, 1'b1, 8'hAA);
        send_byte(1'b0, 1'b1, 8'h55);
        send_byte(1'b0, 1'b1, 8'hCC);
        send_byte(1'b0, 1'b0, 8'h00);
        checks++; if (valid_cnt != 1 || o_err !== 1'b1) begin
            failures++; $display("FAIL odd_bytes got=cnt%0d err%b exp=cnt1 err1", valid_cnt, o_err); end
        send_byte(1'b0, 1'b1, 8'h00);
        send_byte(1'b0, 1'b1, 8'h00);
        checks++; if (o_valid !== 1'b1 || x_pixel !== 10'd0 || y_pixel !== 10'd1) begin
            failures++; $display("FAIL odd_next_line got=%b x=%0d y=%0d exp=1 x=0 y=1", o_valid, x_pixel, y_pixel); end
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_vsync_abort();
        start_frame();
        valid_cnt = 0;
        fd_cnt = 0;
        for (int l = 0; l < 2; l++) begin
            for (int b = 0; b < 4; b++) send_byte(1'b0, 1'b1, 8'h3C);
            send_byte(1'b0, 1'b0, 8'h00);
        end
        for (int b = 0; b < 3; b++) send_byte(1'b0, 1'b1, 8'h3C);
        send_byte(1'b1, 1'b1, 8'h3C);
        repeat (2) @(negedge clk);
        checks++; if (fd_cnt != 1) begin
            failures++; $display("FAIL abort_frame_done got=%0d exp=1", fd_cnt); end
        for (int b = 0; b < 4; b++) send_byte(1'b1, 1'b1, 8'h3C);
        send_byte(1'b0, 1'b0, 8'h00);
        checks++; if (valid_cnt != 5 || fd_cnt != 1) begin
            failures++; $display("FAIL abort_counts got=v%0d fd%0d exp=v5 fd1", valid_cnt, fd_cnt); end
    endtask

    task automatic test_reset_mid_pixel();
        int v0;
        int f0;
        send_byte(1'b0, 1'b1, 8'hFF);
        v0 = valid_cnt;
        f0 = fd_cnt;
        reset = 1'b0;
        cam_href = 1'b1;
        cam_data = 8'hFF;
        byte_en = 1'b1;
        repeat (2) @(negedge clk);
        byte_en = 1'b0;
        reset = 1'b1;
        send_byte(1'b0, 1'b1, 8'hFF);
        send_byte(1'b0, 1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        checks++; if (valid_cnt != v0 || fd_cnt != f0 || o_err !== 1'b0) begin
            failures++; $display("FAIL rst_mid got=v%0d fd%0d err%b exp=v%0d fd%0d err0",
                                 valid_cnt, fd_cnt, o_err, v0, f0); end
        start_frame();
        send_byte(1'b0, 1'b1, 8'hA0);
        send_byte(1'b0, 1'b1, 8'h00);
        checks++; if (o_valid !== 1'b1 || o_sof !== 1'b1 || x_pixel !== 10'd0 || y_pixel !== 10'd0) begin
            failures++; $display("FAIL rst_first_px got=%b%b x=%0d y=%0d exp=11 x=0 y=0", o_valid, o_sof, x_pixel, y_pixel); end
`ifndef CAPTURE_GRAYSCALE_EN
        checks++; if ({o_r, o_g, o_b} !== 12'hA00) begin
            failures++; $display("FAIL rst_first_rgb got=%h exp=a00", {o_r, o_g, o_b}); end
`else
        checks++; if ({o_r, o_g, o_b} !== 12'h222) begin
            failures++; $display("FAIL rst_first_luma got=%h exp=222", {o_r, o_g, o_b}); end
`endif
    endtask

    task automatic test_white();
        send_byte(1'b0, 1'b1, 8'hFF);
        send_byte(1'b0, 1'b1, 8'hFF);
        checks++; if (o_valid !== 1'b1 || {o_r, o_g, o_b} !== 12'hFFF || x_pixel !== 10'd1) begin
            failures++; $display("FAIL white got=%b %h x=%0d exp=1 fff x=1", o_valid, {o_r, o_g, o_b}, x_pixel); end
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_two_pixels();
        test_line_overflow();
        test_odd_bytes();
        test_vsync_abort();
        test_reset_mid_pixel();
        test_white();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
